// File: rtl/phy_mem_ctrl.sv
// Round-robin arbiter of NUM_CH requesters onto one word RAM plus a memory-mapped GPIO register.
// Latency: accept edge, WAIT_STATES wait cycles, then a one-cycle ACK; next accept one cycle later.
// Backpressure: REQ is held until that channel's ACK; losing channels simply wait in IDLE.
module phy_mem_ctrl #(
    parameter int          NUM_CH      = 2,
    parameter int          DW          = 32,
    parameter int          AW          = 16,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1,
    parameter int          GPIO_W      = 8,
    parameter logic [AW-1:0] IO_ADDR   = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      req,
    input  logic [NUM_CH-1:0]      we,
    input  logic [NUM_CH*AW-1:0]   addr,
    input  logic [NUM_CH*DW-1:0]   wdata,
    input  logic [NUM_CH*DW/8-1:0] be,
    output logic [NUM_CH-1:0]      ack,
    output logic [DW-1:0]          rdata,
    output logic [GPIO_W-1:0]      gpio_out
);

    localparam int BW    = DW / 8;
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DAW   = $clog2(DEPTH);
    localparam int WSW   = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam int WLAST = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]     state;
    logic [WSW-1:0] cnt;
    logic [CW-1:0]  gnt;
    logic [CW-1:0]  last;
    logic           lat_we;
    logic [AW-1:0]  lat_addr;
    logic [DW-1:0]  lat_wdata;
    logic [BW-1:0]  lat_be;

    logic [DW-1:0]  mem [DEPTH];

    logic [AW-1:0]  addr_a  [NUM_CH];
    logic [DW-1:0]  wdata_a [NUM_CH];
    logic [BW-1:0]  be_a    [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign addr_a[i]  = addr[i*AW +: AW];
        assign wdata_a[i] = wdata[i*DW +: DW];
        assign be_a[i]    = be[i*BW +: BW];
    end

    // Search from last+1 with wrap; iterating downward lets the nearest requester win.
    logic          gnt_found;
    logic [CW-1:0] gnt_nxt;

    always_comb begin
        gnt_found = 1'b0;
        gnt_nxt   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[(int'(last) + 1 + k) % NUM_CH]) begin
                gnt_found = 1'b1;
                gnt_nxt   = CW'((int'(last) + 1 + k) % NUM_CH);
            end
        end
    end

    logic          lat_io;
    logic [AW-1:0] sel_addr;
    logic          sel_io;
    logic [DW-1:0] sel_word;
    logic          load_rd;
    logic [DW-1:0] bmask;

    assign lat_io   = (lat_addr == IO_ADDR);
    assign sel_addr = (state == S_IDLE) ? addr_a[gnt_nxt] : lat_addr;
    assign sel_io   = (sel_addr == IO_ADDR);
    assign sel_word = mem[sel_addr[DAW-1:0]];

    // Read data is registered on the edge entering RESP, so it is valid for the whole ACK cycle.
    assign load_rd = ((state == S_IDLE) && gnt_found && (WAIT_STATES == 0) && !we[gnt_nxt]) ||
                     ((state == S_WAIT) && (cnt == WSW'(WLAST)) && !lat_we);

    always_comb begin
        bmask = '0;
        for (int k = 0; k < BW; k++) begin
            bmask[k*8 +: 8] = {8{lat_be[k]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            gnt       <= '0;
            last      <= CW'(NUM_CH - 1);
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rdata     <= '0;
        end else begin
            if (load_rd) begin
                rdata <= sel_io ? DW'(gpio_out) : sel_word;
            end
            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        gnt       <= gnt_nxt;
                        last      <= gnt_nxt;
                        lat_we    <= we[gnt_nxt];
                        lat_addr  <= addr_a[gnt_nxt];
                        lat_wdata <= wdata_a[gnt_nxt];
                        lat_be    <= be_a[gnt_nxt];
                        cnt       <= '0;
                        state     <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (cnt == WSW'(WLAST)) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out <= '0;
        end else if ((state == S_RESP) && lat_we && lat_io) begin
            gpio_out <= (gpio_out & ~bmask[GPIO_W-1:0]) | (lat_wdata[GPIO_W-1:0] & bmask[GPIO_W-1:0]);
        end
    end

    // RAM is never reset; a reset during RESP drops state to IDLE so the commit cannot happen.
    always_ff @(posedge clk) begin
        if ((state == S_RESP) && lat_we && !lat_io) begin
            for (int k = 0; k < BW; k++) begin
                if (lat_be[k]) begin
                    mem[lat_addr[DAW-1:0]][k*8 +: 8] <= lat_wdata[k*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        ack = '0;
        if (state == S_RESP) begin
            ack[gnt] = 1'b1;
        end
    end

endmodule

// File: tb/tb_phy_mem_ctrl.sv
// Scoreboard bench for phy_mem_ctrl: expected ACK channel/read data queued at request time,
// popped by a monitor on every ACK; inputs driven on negedge, outputs sampled on negedge.
`timescale 1ns/1ps
module tb_phy_mem_ctrl;

    localparam int NUM_CH = 2;
    localparam int DW     = 32;
    localparam int AW     = 16;
    localparam int WS     = 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NUM_CH-1:0]      req = '0;
    logic [NUM_CH-1:0]      we = '0;
    logic [NUM_CH*AW-1:0]   addr = '0;
    logic [NUM_CH*DW-1:0]   wdata = '0;
    logic [NUM_CH*DW/8-1:0] be = '0;
    logic [NUM_CH-1:0]      ack;
    logic [DW-1:0]          rdata;
    logic [7:0]             gpio_out;

    phy_mem_ctrl #(
        .NUM_CH(NUM_CH), .DW(DW), .AW(AW), .DEPTH(1024),
        .WAIT_STATES(WS), .GPIO_W(8), .IO_ADDR(16'hFFFF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .ack(ack), .rdata(rdata), .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    typedef struct {
        int          ch;
        logic        rd;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];

    task automatic sb_push(input int ch, input logic rd, input logic [31:0] d);
        exp_t e;
        e.ch = ch;
        e.rd = rd;
        e.d  = d;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && ack !== '0) begin
            chk("ack_onehot", 32'($countones(ack)), 32'd1);
            if (sb.size() == 0) begin
                chk("spurious_ack", 32'(ack), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_ch", 32'(ack), 32'd1 << e.ch);
                if (e.rd) chk("rdata", rdata, e.d);
            end
        end
    end

    // Single access on one channel; checks the accept-to-ACK latency.
    task automatic access(input int ch, input logic w, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] b, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        req[ch] = 1'b1;
        we[ch]  = w;
        addr[ch*AW +: AW]  = a;
        wdata[ch*DW +: DW] = d;
        be[ch*4 +: 4]      = b;
        sb_push(ch, !w, exp);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ack[ch]) begin
                lat = i;
                break;
            end
        end
        req[ch] = 1'b0;
        chk("ack_latency", 32'(lat), 32'(WS + 1));
    endtask

    int t_ack [4];
    int n_ack;

    initial begin
        // 1: reset state, idle with no requests
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_gpio", 32'(gpio_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_ack", 32'(ack), 32'd0);
            chk("idle_gpio", 32'(gpio_out), 32'd0);
        end
        chk("idle_rdata", rdata, 32'd0);

        // 2: full-word write then read
        access(0, 1'b1, 16'd5, 32'hDEADBEEF, 4'b1111, 32'h0);
        access(0, 1'b0, 16'd5, 32'h0, 4'b0000, 32'hDEADBEEF);

        // 3: byte-enabled write from ch1, read through an aliased address
        access(1, 1'b1, 16'd5, 32'h0000AA00, 4'b0010, 32'h0);
        access(1, 1'b0, 16'd1029, 32'h0, 4'b0000, 32'hDEADAAEF);

        // BE=0 write must be acknowledged but change nothing
        access(0, 1'b1, 16'd5, 32'hFFFFFFFF, 4'b0000, 32'h0);
        access(0, 1'b0, 16'd5, 32'h0, 4'b0000, 32'hDEADAAEF);

        // 4: both channels hold read requests; last grant was ch0, so ch1 leads
        @(negedge clk);
        req = '1;
        we  = '0;
        addr[0 +: AW]  = 16'd5;
        addr[AW +: AW] = 16'd1029;
        sb_push(1, 1'b1, 32'hDEADAAEF);
        sb_push(0, 1'b1, 32'hDEADAAEF);
        sb_push(1, 1'b1, 32'hDEADAAEF);
        sb_push(0, 1'b1, 32'hDEADAAEF);
        n_ack = 0;
        for (int i = 0; i < 40 && n_ack < 4; i++) begin
            @(negedge clk);
            if (ack !== '0) begin
                t_ack[n_ack] = cyc;
                n_ack++;
            end
        end
        req = '0;
        chk("rr_count", 32'(n_ack), 32'd4);
        for (int i = 1; i < 4; i++) begin
            chk("rr_spacing", 32'(t_ack[i] - t_ack[i-1]), 32'(WS + 2));
        end

        // 5: GPIO write with byte enable, then GPIO read
        access(0, 1'b1, 16'hFFFF, 32'h1234565A, 4'b0001, 32'h0);
        chk("gpio_before_edge", 32'(gpio_out), 32'h00);
        @(negedge clk);
        chk("gpio_after_edge", 32'(gpio_out), 32'h5A);
        access(0, 1'b0, 16'hFFFF, 32'h0, 4'b0000, 32'h0000005A);

        // 6: reset during WAIT abandons the write and clears GPIO
        access(0, 1'b1, 16'd7, 32'hCAFEF00D, 4'b1111, 32'h0);
        @(negedge clk);
        req[0] = 1'b1;
        we[0]  = 1'b1;
        addr[0 +: AW]  = 16'd7;
        wdata[0 +: DW] = 32'h11111111;
        be[0 +: 4]     = 4'b1111;
        @(negedge clk);
        chk("wait_no_ack", 32'(ack), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_gpio", 32'(gpio_out), 32'h00);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_no_ack", 32'(ack), 32'd0);
        end
        chk("postrst_gpio", 32'(gpio_out), 32'h00);
        access(0, 1'b0, 16'd7, 32'h0, 4'b0000, 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
